combination_block: RTL and testbench
====================================

Name: combination_block

Overview:
Aggregation stage of the GCN datapath. After the transformation stage signals completion, it walks a COO edge list and computes ADJ_FM_WM = A × FM_WM. For every edge (src, dst) in 1-indexed node numbering, row dst-1 of the result accumulates row src-1 of FM_WM. Results are held in an internal row bank and read back one row at a time by the downstream stage.

Parameters:
FEATURE_ROWS, 6, number of graph nodes (rows of FM_WM and ADJ_FM_WM)
WEIGHT_COLS, 3, elements per row
DOT_PROD_WIDTH, 16, bits per element
COO_NUM_OF_COLS, 6, number of edges in the COO list
COO_BW, $clog2(COO_NUM_OF_COLS), width of a node id in coo_in
FEATURE_WIDTH, $clog2(FEATURE_ROWS), row-index width
COO_ADDRESS_WIDTH, COO_BW, edge-address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
done_trans  in  1  level; FM_WM ready, start aggregation
coo_in[0:1]  in  2×COO_BW  edge at coo_address; [0]=source id, [1]=destination id, 1-indexed; combinational from coo_address
fm_wm_row_data[0:WEIGHT_COLS-1]  in  WEIGHT_COLS×DOT_PROD_WIDTH  FM_WM row at read_fm_wm_row; combinational
read_row  in  FEATURE_WIDTH  result row select
coo_address  out  COO_ADDRESS_WIDTH  edge index being fetched
read_fm_wm_row  out  FEATURE_WIDTH  FM_WM row requested (0-indexed)
done_comb  out  1  aggregation complete, sticky
adj_fm_wm_row[0:WEIGHT_COLS-1]  out  WEIGHT_COLS×DOT_PROD_WIDTH  result row read_row

Behaviour:
- Reset (reset=0, async): state IDLE; coo_address=0, read_fm_wm_row=0, done_comb=0; all FEATURE_ROWS×WEIGHT_COLS accumulators cleared to 0, so adj_fm_wm_row=0.
- FSM states:
  - IDLE: coo_address=0. On a clk edge with done_trans=1, go to FETCH with edge counter e=0.
  - FETCH: coo_address=e. Register src_q=coo_in[0] and dst_q=coo_in[1]. Go to ACC.
  - ACC: read_fm_wm_row=src_q-1; for each column j, acc[dst_q-1][j] += fm_wm_row_data[j]. If e==COO_NUM_OF_COLS-1, go to DONE; else e++ and go to FETCH.
  - DONE: done_comb=1, held until reset. done_trans is ignored; there is no restart without reset.
- Each edge takes 2 cycles. done_comb rises 2·COO_NUM_OF_COLS+1 rising edges after the edge that samples done_trans=1 (13 cycles at the defaults).
- Arithmetic: unsigned, modulo 2^DOT_PROD_WIDTH, no saturation.
- Invalid node id: if src or dst is 0 or greater than FEATURE_ROWS, the edge is skipped (no write) but still counted.
- Duplicate edges accumulate again. Self-loops (src==dst) are legal.
- Aggregation is directed: only the dst row accumulates.
- read_fm_wm_row holds its last value outside ACC.
- adj_fm_wm_row is a combinational read of acc[read_row]. If read_row ≥ FEATURE_ROWS it returns all zeros. The value is valid at any time; after done_comb it is final.
- Reset mid-aggregation: all accumulators clear and the FSM returns to IDLE. A new run starts when done_trans is seen high again.

Decomposition:
- Shared package gcn_pkg:
  - elem_t = logic [DOT_PROD_WIDTH-1:0]
  - row_t = elem_t [WEIGHT_COLS]
  - the FSM state enum {IDLE, FETCH, ACC, DONE}
- One sub-module, adj_row_accumulator. It is the FEATURE_ROWS×row_t register bank with an async clear, a single-row accumulate port (en, idx, row_t addend) and a combinational read port (idx → row_t, zero when out of range).
- The FSM, edge counter and index decrement stay in combination_block.

Test Plan:
- Default graph: FM_WM rows {11488,0,0},{6684,0,0},{7687,6093,0},{7687,9853,8976},{0,6684,8976},{0,6093,6093}; edges (1→2),(2→3),(3→4),(4→5),(4→6),(5→6); done_trans=1 -> done_comb=1. Reading rows 0..5 gives {0,0,0},{11488,0,0},{6684,0,0},{7687,6093,0},{7687,9853,8976},{7687,16537,17952}.
- Check done_comb timing: it is 0 until exactly 13 edges after done_trans is sampled, then stays 1 with done_trans held high or dropped. coo_address sequence is 0..5, and read_fm_wm_row in ACC is 0,1,2,3,3,4.
- Overflow: two edges 1→1 with row0={40000,65535,1} -> row0={14464,65534,2}.
- Invalid ids: edges (0→2),(7→1),(2→0) -> all result rows 0 and done_comb still asserts.
- Reset during the third edge -> outputs go to 0 immediately (async). Restarting with the default graph yields the full golden result.
- read_row=6 or 7 -> adj_fm_wm_row={0,0,0}. Before done_trans, every row reads 0.

Source files
------------

// File: rtl/gcn_pkg.sv
// Shared types and sizing for the GCN aggregation datapath.
// Node ids on the COO bus are 1-indexed; row indices inside the datapath are 0-indexed.
package gcn_pkg;

   localparam int FEATURE_ROWS      = 6;
   localparam int WEIGHT_COLS       = 3;
   localparam int DOT_PROD_WIDTH    = 16;
   localparam int COO_NUM_OF_COLS   = 6;
   localparam int COO_BW            = $clog2(COO_NUM_OF_COLS);
   localparam int FEATURE_WIDTH     = $clog2(FEATURE_ROWS);
   localparam int COO_ADDRESS_WIDTH = COO_BW;

   typedef logic [DOT_PROD_WIDTH-1:0] elem_t;
   typedef elem_t row_t [WEIGHT_COLS];

   typedef enum logic [1:0] {IDLE, FETCH, ACC, DONE} state_t;

   // A node id is usable only if it names a real row (1..FEATURE_ROWS).
   function automatic logic node_valid(input logic [COO_BW-1:0] id);
      return (id != '0) && (int'(id) <= FEATURE_ROWS);
   endfunction

endpackage

// File: rtl/adj_row_accumulator.sv
// Row bank holding ADJ_FM_WM: one accumulate port, one combinational read port.
// Reads of a row index beyond the bank return zeros.
module adj_row_accumulator
   import gcn_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_acc_en,
   input  logic [FEATURE_WIDTH-1:0] i_acc_idx,
   input  row_t                     i_addend,
   input  logic [FEATURE_WIDTH-1:0] i_rd_idx,
   output row_t                     o_rd_row
);

   row_t r_bank [FEATURE_ROWS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < FEATURE_ROWS; r++) begin
            for (int j = 0; j < WEIGHT_COLS; j++) begin
               r_bank[r][j] <= '0;
            end
         end
      end else if (i_acc_en && (int'(i_acc_idx) < FEATURE_ROWS)) begin
         // Modulo-2^DOT_PROD_WIDTH wraparound is intended.
         for (int j = 0; j < WEIGHT_COLS; j++) begin
            r_bank[i_acc_idx][j] <= r_bank[i_acc_idx][j] + i_addend[j];
         end
      end
   end

   always_comb begin
      for (int j = 0; j < WEIGHT_COLS; j++) begin
         o_rd_row[j] = '0;
      end
      if (int'(i_rd_idx) < FEATURE_ROWS) begin
         o_rd_row = r_bank[i_rd_idx];
      end
   end

endmodule

// File: rtl/combination_block.sv
// GCN aggregation stage: walks the COO edge list once per run and accumulates
// FM_WM[src-1] into ADJ_FM_WM[dst-1]; two cycles per edge (FETCH, ACC).
module combination_block
   import gcn_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         done_trans,
   input  logic [COO_BW-1:0]            coo_in [0:1],
   input  logic [DOT_PROD_WIDTH-1:0]    fm_wm_row_data [0:WEIGHT_COLS-1],
   input  logic [FEATURE_WIDTH-1:0]     read_row,
   output logic [COO_ADDRESS_WIDTH-1:0] coo_address,
   output logic [FEATURE_WIDTH-1:0]     read_fm_wm_row,
   output logic                         done_comb,
   output logic [DOT_PROD_WIDTH-1:0]    adj_fm_wm_row [0:WEIGHT_COLS-1],
   output logic [1:0]                   o_dbg_state
);

   state_t                         r_state;
   logic [COO_ADDRESS_WIDTH-1:0]   r_edge;
   logic [COO_ADDRESS_WIDTH-1:0]   r_coo_address;
   logic [FEATURE_WIDTH-1:0]       r_read_fm_wm_row;
   logic [FEATURE_WIDTH-1:0]       r_dst_idx;
   logic                           r_edge_valid;
   logic                           r_done_comb;

   logic [FEATURE_WIDTH-1:0]       w_src_idx;
   logic [FEATURE_WIDTH-1:0]       w_dst_idx;
   logic                           w_acc_en;
   row_t                           w_addend;
   row_t                           w_rd_row;

   assign w_src_idx = FEATURE_WIDTH'(coo_in[0] - COO_BW'(1));
   assign w_dst_idx = FEATURE_WIDTH'(coo_in[1] - COO_BW'(1));
   assign w_acc_en  = (r_state == ACC) && r_edge_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state          <= IDLE;
         r_edge           <= '0;
         r_coo_address    <= '0;
         r_read_fm_wm_row <= '0;
         r_dst_idx        <= '0;
         r_edge_valid     <= 1'b0;
         r_done_comb      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_coo_address <= '0;
               if (done_trans) begin
                  r_edge  <= '0;
                  r_state <= FETCH;
               end
            end
            FETCH: begin
               // Invalid edges still consume their slot but never write.
               r_read_fm_wm_row <= w_src_idx;
               r_dst_idx        <= w_dst_idx;
               r_edge_valid     <= node_valid(coo_in[0]) && node_valid(coo_in[1]);
               r_state          <= ACC;
            end
            ACC: begin
               if (r_edge == COO_ADDRESS_WIDTH'(COO_NUM_OF_COLS - 1)) begin
                  r_state <= DONE;
               end else begin
                  r_edge        <= r_edge + 1'b1;
                  r_coo_address <= r_edge + 1'b1;
                  r_state       <= FETCH;
               end
            end
            DONE: begin
               r_done_comb <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      for (int j = 0; j < WEIGHT_COLS; j++) begin
         w_addend[j]      = fm_wm_row_data[j];
         adj_fm_wm_row[j] = w_rd_row[j];
      end
   end

   adj_row_accumulator u_acc (
      .clk      (clk),
      .reset    (reset),
      .i_acc_en (w_acc_en),
      .i_acc_idx(r_dst_idx),
      .i_addend (w_addend),
      .i_rd_idx (read_row),
      .o_rd_row (w_rd_row)
   );

   assign coo_address    = r_coo_address;
   assign read_fm_wm_row = r_read_fm_wm_row;
   assign done_comb      = r_done_comb;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_combination_block.sv
// Directed bench for combination_block: golden graph, timing, overflow,
// invalid ids, asynchronous reset mid-run and out-of-range reads.
module tb_combination_block;

   logic        clk;
   logic        reset;
   logic        done_trans;
   logic [2:0]  coo_in [0:1];
   logic [15:0] fm_wm_row_data [0:2];
   logic [2:0]  read_row;
   logic [2:0]  coo_address;
   logic [2:0]  read_fm_wm_row;
   logic        done_comb;
   logic [15:0] adj_fm_wm_row [0:2];
   logic [1:0]  o_dbg_state;

   int pass_cnt;
   int total_cnt;

   logic [2:0]  tb_src [0:7];
   logic [2:0]  tb_dst [0:7];
   logic [15:0] tb_fm  [0:7][0:2];
   logic [15:0] exp_rows [0:5][0:2];

   combination_block dut (
      .clk           (clk),
      .reset         (reset),
      .done_trans    (done_trans),
      .coo_in        (coo_in),
      .fm_wm_row_data(fm_wm_row_data),
      .read_row      (read_row),
      .coo_address   (coo_address),
      .read_fm_wm_row(read_fm_wm_row),
      .done_comb     (done_comb),
      .adj_fm_wm_row (adj_fm_wm_row),
      .o_dbg_state   (o_dbg_state)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream memories: combinational, like the transformation stage and COO ROM.
   always_comb begin
      coo_in[0] = tb_src[coo_address];
      coo_in[1] = tb_dst[coo_address];
      for (int j = 0; j < 3; j++) fm_wm_row_data[j] = tb_fm[read_fm_wm_row][j];
   end

   task automatic apply_reset();
      reset      = 1'b0;
      done_trans = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic clear_tables();
      for (int r = 0; r < 8; r++) begin
         tb_src[r] = 3'd0;
         tb_dst[r] = 3'd0;
         for (int j = 0; j < 3; j++) tb_fm[r][j] = 16'd0;
      end
      for (int r = 0; r < 6; r++)
         for (int j = 0; j < 3; j++) exp_rows[r][j] = 16'd0;
   endtask

   task automatic load_default();
      logic [15:0] fm [0:5][0:2];
      logic [2:0]  s [0:5];
      logic [2:0]  d [0:5];
      clear_tables();
      fm = '{'{16'd11488, 16'd0, 16'd0}, '{16'd6684, 16'd0, 16'd0},
             '{16'd7687, 16'd6093, 16'd0}, '{16'd7687, 16'd9853, 16'd8976},
             '{16'd0, 16'd6684, 16'd8976}, '{16'd0, 16'd6093, 16'd6093}};
      s = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5};
      d = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6};
      for (int r = 0; r < 6; r++) begin
         tb_src[r] = s[r];
         tb_dst[r] = d[r];
         for (int j = 0; j < 3; j++) tb_fm[r][j] = fm[r][j];
      end
      exp_rows = '{'{16'd0, 16'd0, 16'd0}, '{16'd11488, 16'd0, 16'd0},
                   '{16'd6684, 16'd0, 16'd0}, '{16'd7687, 16'd6093, 16'd0},
                   '{16'd7687, 16'd9853, 16'd8976}, '{16'd7687, 16'd16537, 16'd17952}};
   endtask

   // Start a run and wait a fixed budget past the expected completion.
   task automatic run_fixed();
      @(negedge clk);
      done_trans = 1'b1;
      repeat (16) @(posedge clk);
      @(negedge clk);
      done_trans = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      total_cnt++;
      if (done_comb !== 1'b0) $display("FAIL reset_done_comb got=%0b exp=0", done_comb);
      else pass_cnt++;
      total_cnt++;
      if (coo_address !== 3'd0) $display("FAIL reset_coo_address got=%0d exp=0", coo_address);
      else pass_cnt++;
      total_cnt++;
      if (read_fm_wm_row !== 3'd0) $display("FAIL reset_read_fm_wm_row got=%0d exp=0", read_fm_wm_row);
      else pass_cnt++;
      for (int r = 0; r < 8; r++) begin
         read_row = r[2:0];
         #1;
         for (int j = 0; j < 3; j++) begin
            total_cnt++;
            if (adj_fm_wm_row[j] !== 16'd0)
               $display("FAIL reset_row r=%0d j=%0d got=%0d exp=0", r, j, adj_fm_wm_row[j]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_default_graph();
      logic [2:0] exp_rd [0:5];
      exp_rd = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4};
      load_default();
      apply_reset();
      @(negedge clk);
      done_trans = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k <= 13; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         if (k <= 10 && k % 2 == 0) begin
            total_cnt++;
            if (coo_address !== 3'(k / 2))
               $display("FAIL seq_coo_address k=%0d got=%0d exp=%0d", k, coo_address, k / 2);
            else pass_cnt++;
         end
         if (k <= 11 && k % 2 == 1) begin
            total_cnt++;
            if (read_fm_wm_row !== exp_rd[(k - 1) / 2])
               $display("FAIL seq_read_fm_wm_row k=%0d got=%0d exp=%0d", k, read_fm_wm_row, exp_rd[(k - 1) / 2]);
            else pass_cnt++;
         end
         total_cnt++;
         if (done_comb !== (k == 13))
            $display("FAIL done_timing k=%0d got=%0b exp=%0b", k, done_comb, k == 13);
         else pass_cnt++;
      end
      // done_trans still high: must not restart.
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if (done_comb !== 1'b1) $display("FAIL done_sticky_high got=%0b exp=1", done_comb);
      else pass_cnt++;
      @(negedge clk);
      done_trans = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if (done_comb !== 1'b1) $display("FAIL done_sticky_low got=%0b exp=1", done_comb);
      else pass_cnt++;
      for (int r = 0; r < 6; r++) begin
         read_row = r[2:0];
         #1;
         for (int j = 0; j < 3; j++) begin
            total_cnt++;
            if (adj_fm_wm_row[j] !== exp_rows[r][j])
               $display("FAIL golden_row r=%0d j=%0d got=%0d exp=%0d", r, j, adj_fm_wm_row[j], exp_rows[r][j]);
            else pass_cnt++;
         end
      end
      for (int r = 6; r < 8; r++) begin
         read_row = r[2:0];
         #1;
         for (int j = 0; j < 3; j++) begin
            total_cnt++;
            if (adj_fm_wm_row[j] !== 16'd0)
               $display("FAIL out_of_range_row r=%0d j=%0d got=%0d exp=0", r, j, adj_fm_wm_row[j]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_overflow();
      clear_tables();
      tb_fm[0][0] = 16'd40000;
      tb_fm[0][1] = 16'd65535;
      tb_fm[0][2] = 16'd1;
      tb_src[0] = 3'd1; tb_dst[0] = 3'd1;
      tb_src[1] = 3'd1; tb_dst[1] = 3'd1;
      exp_rows[0][0] = 16'd14464;
      exp_rows[0][1] = 16'd65534;
      exp_rows[0][2] = 16'd2;
      apply_reset();
      run_fixed();
      #1;
      total_cnt++;
      if (done_comb !== 1'b1) $display("FAIL overflow_done got=%0b exp=1", done_comb);
      else pass_cnt++;
      for (int r = 0; r < 6; r++) begin
         read_row = r[2:0];
         #1;
         for (int j = 0; j < 3; j++) begin
            total_cnt++;
            if (adj_fm_wm_row[j] !== exp_rows[r][j])
               $display("FAIL overflow_row r=%0d j=%0d got=%0d exp=%0d", r, j, adj_fm_wm_row[j], exp_rows[r][j]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_invalid_ids();
      load_default();
      for (int r = 0; r < 6; r++)
         for (int j = 0; j < 3; j++) exp_rows[r][j] = 16'd0;
      tb_src[0] = 3'd0; tb_dst[0] = 3'd2;
      tb_src[1] = 3'd7; tb_dst[1] = 3'd1;
      tb_src[2] = 3'd2; tb_dst[2] = 3'd0;
      tb_src[3] = 3'd0; tb_dst[3] = 3'd0;
      tb_src[4] = 3'd7; tb_dst[4] = 3'd7;
      tb_src[5] = 3'd3; tb_dst[5] = 3'd7;
      apply_reset();
      run_fixed();
      #1;
      total_cnt++;
      if (done_comb !== 1'b1) $display("FAIL invalid_done got=%0b exp=1", done_comb);
      else pass_cnt++;
      for (int r = 0; r < 6; r++) begin
         read_row = r[2:0];
         #1;
         for (int j = 0; j < 3; j++) begin
            total_cnt++;
            if (adj_fm_wm_row[j] !== 16'd0)
               $display("FAIL invalid_row r=%0d j=%0d got=%0d exp=0", r, j, adj_fm_wm_row[j]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_mid_run();
      load_default();
      apply_reset();
      @(negedge clk);
      done_trans = 1'b1;
      repeat (6) @(posedge clk);   // edges 0..5: third edge is now in ACC
      #1;
      read_row = 3'd1;
      #1;
      total_cnt++;
      if (adj_fm_wm_row[0] !== 16'd11488)
         $display("FAIL midrun_partial got=%0d exp=11488", adj_fm_wm_row[0]);
      else pass_cnt++;
      reset = 1'b0;
      #1;
      total_cnt++;
      if (adj_fm_wm_row[0] !== 16'd0) $display("FAIL midrun_async_clear got=%0d exp=0", adj_fm_wm_row[0]);
      else pass_cnt++;
      total_cnt++;
      if (coo_address !== 3'd0) $display("FAIL midrun_coo_address got=%0d exp=0", coo_address);
      else pass_cnt++;
      total_cnt++;
      if (read_fm_wm_row !== 3'd0) $display("FAIL midrun_read_fm_wm_row got=%0d exp=0", read_fm_wm_row);
      else pass_cnt++;
      total_cnt++;
      if (o_dbg_state !== 2'd0) $display("FAIL midrun_state got=%0d exp=0", o_dbg_state);
      else pass_cnt++;
      done_trans = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if (o_dbg_state !== 2'd0) $display("FAIL idle_without_done_trans got=%0d exp=0", o_dbg_state);
      else pass_cnt++;
      run_fixed();
      #1;
      total_cnt++;
      if (done_comb !== 1'b1) $display("FAIL restart_done got=%0b exp=1", done_comb);
      else pass_cnt++;
      for (int r = 0; r < 6; r++) begin
         read_row = r[2:0];
         #1;
         for (int j = 0; j < 3; j++) begin
            total_cnt++;
            if (adj_fm_wm_row[j] !== exp_rows[r][j])
               $display("FAIL restart_row r=%0d j=%0d got=%0d exp=%0d", r, j, adj_fm_wm_row[j], exp_rows[r][j]);
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      pass_cnt   = 0;
      total_cnt  = 0;
      reset      = 1'b0;
      done_trans = 1'b0;
      read_row   = 3'd0;
      clear_tables();
      test_reset();
      test_default_graph();
      test_overflow();
      test_invalid_ids();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
